bus_slave_responder: RTL and testbench

//  Slave-side end of the shared Yutorina bus. The address decoder picks a slave and drives
//  its chip_select_; this block answers that request: address/rw/data latched, programmable

---
 rtl/bus_slave_responder_pkg.sv | 21 ++
 rtl/bus_slave_responder_register_file.sv | 41 ++++
 rtl/bus_slave_responder.sv | 130 +++++++++++++
 tb/tb_bus_slave_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_responder_pkg.sv
// Shared bus encodings and types for the Yutorina slave responder.
package bus_slave_responder_pkg;

  localparam int unsigned WordAddrW  = 30;
  localparam int unsigned WordDataW  = 32;
  localparam int unsigned WaitCountW = 4;

  // Transfer direction as driven on read_write.
  localparam logic BusRead  = 1'b1;
  localparam logic BusWrite = 1'b0;

  typedef logic [WaitCountW-1:0] wait_count_t;
  typedef logic [WordDataW-1:0]  word_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } slave_state_e;

endpackage

// File: rtl/bus_slave_responder_register_file.sv
// Word register bank: synchronous write, asynchronous read, register 0 tapped out.
module bus_slave_responder_register_file
  import bus_slave_responder_pkg::*;
#(
  parameter int unsigned REG_COUNT   = 8,
  parameter word_t       RESET_VALUE = '0,
  localparam int unsigned IdxW       = $clog2(REG_COUNT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  word_t           wdata_i,
  input  logic [IdxW-1:0] raddr_i,
  output word_t           rdata_o,
  output word_t           reg0_o
);

  logic [REG_COUNT-1:0][WordDataW-1:0] regs_d, regs_q;

  // Next-state of the bank: only the addressed word changes on a write.
  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Bank storage with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= {REG_COUNT{RESET_VALUE}};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_o = regs_q[raddr_i];
  assign reg0_o  = regs_q[0];

endmodule

// File: rtl/bus_slave_responder.sv
// Slave-side responder: latches a selected request, waits WAIT_CYCLES, pulses ready_ once.
module bus_slave_responder
  import bus_slave_responder_pkg::*;
#(
  parameter int unsigned REG_COUNT   = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter word_t       RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic                 chip_select_,
  input  logic                 address_strobe_,
  input  logic [WordAddrW-1:0] slave_address,
  input  logic                 read_write,
  input  logic [WordDataW-1:0] write_data,
  output logic [WordDataW-1:0] read_data,
  output logic                 ready_,
  output logic [WordDataW-1:0] control_out
);

  localparam int unsigned IdxW = $clog2(REG_COUNT);

  slave_state_e    state_d, state_q;
  wait_count_t     count_d, count_q;
  logic [IdxW-1:0] idx_d, idx_q;
  logic            rw_d, rw_q;
  word_t           wdata_d, wdata_q;
  word_t           rdata_d, rdata_q;
  logic            ready_d, ready_q;

  logic            rf_we;
  logic [IdxW-1:0] rf_raddr;
  word_t           rf_rdata;
  logic            accept;

  // Upper address bits alias onto the same register window.
  logic unused_addr;
  assign unused_addr = ^slave_address[WordAddrW-1:IdxW];

  assign accept = !chip_select_ && !address_strobe_;

  // With zero wait states the read completes straight out of IDLE, so the live address is used.
  assign rf_raddr = (state_q == StIdle) ? slave_address[IdxW-1:0] : idx_q;
  assign rf_we    = (state_q == StReady) && (rw_q == BusWrite);

  // Next-state, request latch and registered output values.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    ready_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d   = slave_address[IdxW-1:0];
          rw_d    = read_write;
          wdata_d = write_data;
          count_d = WaitCountW'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = StReady;
            ready_d = 1'b0;
            if (read_write == BusRead) begin
              rdata_d = rf_rdata;
            end
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        count_d = count_q - wait_count_t'(1);
        if (count_q == wait_count_t'(1)) begin
          state_d = StReady;
          ready_d = 1'b0;
          if (rw_q == BusRead) begin
            rdata_d = rf_rdata;
          end
        end
      end
      StReady: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM, counter, latch and output registers; reset drops any pending request.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      rw_q    <= BusRead;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  bus_slave_responder_register_file #(
    .REG_COUNT  (REG_COUNT),
    .RESET_VALUE(RESET_VALUE)
  ) u_register_file (
    .clk_i  (clock),
    .rst_ni (reset_),
    .we_i   (rf_we),
    .waddr_i(idx_q),
    .wdata_i(wdata_q),
    .raddr_i(rf_raddr),
    .rdata_o(rf_rdata),
    .reg0_o (control_out)
  );

  assign read_data = rdata_q;
  assign ready_    = ready_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed bench: one DUT with two wait states, one with zero wait states and nonzero reset value.
module tb_bus_slave_responder;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        cs2_ = 1'b1;
  logic        cs0_ = 1'b1;
  logic        strobe_ = 1'b1;
  logic [29:0] addr = '0;
  logic        rw = 1'b1;
  logic [31:0] wdata = '0;
  logic [31:0] rd2, ctl2, rd0, ctl0;
  logic        rdy2_, rdy0_;

  int errors = 0;
  int checks = 0;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  always #5 clock = ~clock;

  bus_slave_responder #(
    .REG_COUNT  (8),
    .WAIT_CYCLES(2),
    .RESET_VALUE(32'h0000_0000)
  ) u_dut2 (
    .clock          (clock),
    .reset_         (reset_),
    .chip_select_   (cs2_),
    .address_strobe_(strobe_),
    .slave_address  (addr),
    .read_write     (rw),
    .write_data     (wdata),
    .read_data      (rd2),
    .ready_         (rdy2_),
    .control_out    (ctl2)
  );

  bus_slave_responder #(
    .REG_COUNT  (4),
    .WAIT_CYCLES(0),
    .RESET_VALUE(32'h0000_1111)
  ) u_dut0 (
    .clock          (clock),
    .reset_         (reset_),
    .chip_select_   (cs0_),
    .address_strobe_(strobe_),
    .slave_address  (addr),
    .read_write     (rw),
    .write_data     (wdata),
    .read_data      (rd0),
    .ready_         (rdy0_),
    .control_out    (ctl0)
  );

  // Master transaction: hold request until ready_ has been sampled, then release.
  // sel=1 addresses the zero-wait DUT. lat counts negedges after the accepting edge.
  task automatic do_xfer(input bit sel, input logic dir, input logic [29:0] a,
                         input logic [31:0] d, output int lat, output int pulses,
                         output logic [31:0] rdat, output int stray,
                         output logic [31:0] ctl_rdy, output logic [31:0] ctl_next);
    logic r_n;
    logic [31:0] r_d, c;
    lat = -1; pulses = 0; rdat = '0; stray = 0; ctl_rdy = '0; ctl_next = '0;
    @(negedge clock);
    if (sel) cs0_ = 1'b0; else cs2_ = 1'b0;
    strobe_ = 1'b0; addr = a; rw = dir; wdata = d;
    @(posedge clock);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      r_n = sel ? rdy0_ : rdy2_;
      r_d = sel ? rd0 : rd2;
      c   = sel ? ctl0 : ctl2;
      if (lat > 0 && k == lat + 1) begin
        ctl_next = c;
        strobe_ = 1'b1; cs0_ = 1'b1; cs2_ = 1'b1;
      end
      if (r_n == 1'b0) begin
        pulses++;
        if (lat < 0) begin
          lat = k; rdat = r_d; ctl_rdy = c;
        end
      end else if (r_d != 32'h0) begin
        stray++;
      end
    end
    strobe_ = 1'b1; cs0_ = 1'b1; cs2_ = 1'b1;
  endtask

  task automatic test_reset;
    reset_ = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (rdy2_ !== 1'b1) begin errors++; $display("FAIL reset_rdy2 got %b want 1", rdy2_); end
    checks++; if (rdy0_ !== 1'b1) begin errors++; $display("FAIL reset_rdy0 got %b want 1", rdy0_); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h want 0", rd2); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rd0 got %h want 0", rd0); end
    checks++; if (ctl2 !== 32'h0) begin errors++; $display("FAIL reset_ctl2 got %h want 0", ctl2); end
    checks++; if (ctl0 !== 32'h0000_1111) begin errors++; $display("FAIL reset_ctl0 got %h want 00001111", ctl0); end
    reset_ = 1'b1;
  endtask

  task automatic test_write_read;
    int lat, pulses, stray;
    logic [31:0] rdat, cr, cn;
    do_xfer(0, WR, 30'd3, 32'hDEAD_BEEF, lat, pulses, rdat, stray, cr, cn);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr3_latency got %0d want 3", lat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL wr3_pulses got %0d want 1", pulses); end
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL wr3_rdata got %h want 0", rdat); end
    do_xfer(0, RD, 30'd3, 32'h0, lat, pulses, rdat, stray, cr, cn);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd3_latency got %0d want 3", lat); end
    checks++; if (rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd3_data got %h want deadbeef", rdat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL rd3_pulses got %0d want 1", pulses); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rd3_idle_data got %0d nonzero cycles want 0", stray); end
    // Address 11 aliases to index 3 in an 8-register window.
    do_xfer(0, RD, 30'd11, 32'h0, lat, pulses, rdat, stray, cr, cn);
    checks++; if (rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_alias got %h want deadbeef", rdat); end
  endtask

  task automatic test_control;
    int lat, pulses, stray;
    logic [31:0] rdat, cr, cn;
    do_xfer(0, WR, 30'd0, 32'h0000_00A5, lat, pulses, rdat, stray, cr, cn);
    checks++; if (cr !== 32'h0) begin errors++; $display("FAIL ctl_at_ready got %h want 0", cr); end
    checks++; if (cn !== 32'h0000_00A5) begin errors++; $display("FAIL ctl_after_ready got %h want 000000a5", cn); end
  endtask

  task automatic test_no_select;
    int lat, pulses, stray, low;
    logic [31:0] rdat, cr, cn;
    low = 0;
    @(negedge clock);
    strobe_ = 1'b0; rw = WR; addr = 30'd3; wdata = 32'h0BAD_0BAD;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (rdy2_ == 1'b0 || rdy0_ == 1'b0) low++;
    end
    strobe_ = 1'b1;
    checks++; if (low !== 0) begin errors++; $display("FAIL nosel_ready got %0d pulses want 0", low); end
    do_xfer(0, RD, 30'd3, 32'h0, lat, pulses, rdat, stray, cr, cn);
    checks++; if (rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nosel_reg3 got %h want deadbeef", rdat); end
    checks++; if (ctl2 !== 32'h0000_00A5) begin errors++; $display("FAIL nosel_ctl2 got %h want 000000a5", ctl2); end
  endtask

  task automatic test_back_to_back;
    int lat, pulses, stray;
    logic [31:0] rdat, cr, cn, d1, d3;
    logic [7:0] mask;
    do_xfer(1, WR, 30'd1, 32'h0000_0055, lat, pulses, rdat, stray, cr, cn);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w0_latency got %0d want 1", lat); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL w0_pulses got %0d want 1", pulses); end
    // Strobe held over three edges: accepts at the first and third, never the second.
    mask = '0; d1 = '0; d3 = '0;
    @(negedge clock);
    cs0_ = 1'b0; strobe_ = 1'b0; rw = RD; addr = 30'd1;
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      mask[k-1] = ~rdy0_;
      if (k == 1) d1 = rd0;
      if (k == 3) begin
        d3 = rd0; cs0_ = 1'b1; strobe_ = 1'b1;
      end
    end
    checks++; if (mask !== 8'b0000_0101) begin errors++; $display("FAIL b2b_mask got %b want 00000101", mask); end
    checks++; if (d1 !== 32'h55) begin errors++; $display("FAIL b2b_data1 got %h want 00000055", d1); end
    checks++; if (d3 !== 32'h55) begin errors++; $display("FAIL b2b_data2 got %h want 00000055", d3); end
    // Strobe released one cycle into WAIT: the write still completes.
    mask = '0;
    @(negedge clock);
    cs2_ = 1'b0; strobe_ = 1'b0; rw = WR; addr = 30'd6; wdata = 32'hCAFE_F00D;
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin cs2_ = 1'b1; strobe_ = 1'b1; end
      mask[k-1] = ~rdy2_;
    end
    checks++; if (mask !== 8'b0000_0100) begin errors++; $display("FAIL release_mask got %b want 00000100", mask); end
    do_xfer(0, RD, 30'd6, 32'h0, lat, pulses, rdat, stray, cr, cn);
    checks++; if (rdat !== 32'hCAFE_F00D) begin errors++; $display("FAIL release_data got %h want cafef00d", rdat); end
  endtask

  task automatic test_reset_mid_wait;
    int lat, pulses, stray;
    logic [31:0] rdat, cr, cn;
    logic [7:0] mask;
    mask = '0;
    @(negedge clock);
    cs2_ = 1'b0; strobe_ = 1'b0; rw = WR; addr = 30'd5; wdata = 32'h1234_5678;
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin cs2_ = 1'b1; strobe_ = 1'b1; reset_ = 1'b0; end
      if (k == 3) reset_ = 1'b1;
      mask[k-1] = ~rdy2_;
    end
    checks++; if (mask !== 8'h00) begin errors++; $display("FAIL rstwait_mask got %b want 00000000", mask); end
    do_xfer(0, RD, 30'd5, 32'h0, lat, pulses, rdat, stray, cr, cn);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rstwait_rd_latency got %0d want 3", lat); end
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL rstwait_reg5 got %h want 0", rdat); end
    checks++; if (ctl2 !== 32'h0) begin errors++; $display("FAIL rstwait_ctl2 got %h want 0", ctl2); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_control();
    test_no_select();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
